// File: rtl/data_mem_ctrl.sv
// Word-addressed data RAM behind a valid/ready request/response handshake,
// with a programmable number of wait states, byte-enabled writes and out-of-range
// reporting. Optional read/write commit counters appear when DMEM_PERF_CNT_EN is defined.
module data_mem_ctrl #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 6,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err
`ifdef DMEM_PERF_CNT_EN
   ,
   output logic [31:0]         rd_count,
   output logic [31:0]         wr_count
`endif
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;
   logic                rd_keep_q, rd_keep_d;

   logic                accept;
   logic                commit;
   logic                acc_we;
   logic [BE_W-1:0]     acc_be;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic                acc_in_range;
   logic [IDX_W-1:0]    acc_idx;
   logic [DATA_W-1:0]   acc_init;
   logic [BE_W-1:0]     lane_we;
   logic                mem_re;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   mem_rd_q;
   logic [DATA_W-1:0]   rd_init_q;

   // The RAM powers up all-zero; each word is stored XORed with its boot value,
   // so a never-written word reads back as its power-up content.
   function automatic logic [DATA_W-1:0] init_word(input logic [IDX_W-1:0] idx);
      logic [DATA_W-1:0] w;
      w = '0;
      if (int'(idx) == 0) w = DATA_W'(17);
      if (int'(idx) == 1) w = DATA_W'(9);
      if (int'(idx) == 2) w = DATA_W'(25);
      return w;
   endfunction

   assign req_ready = (state_q == IDLE) && !reset;
   assign accept    = req_valid && req_ready;

   // With zero wait states the access happens on the acceptance edge itself,
   // so the live request fields are used while still in IDLE.
   assign acc_we       = (state_q == IDLE) ? req_we    : we_q;
   assign acc_be       = (state_q == IDLE) ? req_be    : be_q;
   assign acc_addr     = (state_q == IDLE) ? req_addr  : addr_q;
   assign acc_wdata    = (state_q == IDLE) ? req_wdata : wdata_q;
   assign acc_in_range = ({1'b0, acc_addr} < (ADDR_W+1)'(DEPTH));
   assign acc_idx      = acc_addr[IDX_W-1:0];
   assign acc_init     = init_word(acc_idx);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      be_d      = be_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      rd_keep_d = rd_keep_q;
      commit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = req_we;
               be_d    = req_be;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (LATENCY == 0) begin
                  commit  = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = 4'(LATENCY);
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d   = IDLE;
               err_d     = 1'b0;
               rd_keep_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (commit) begin
         err_d     = !acc_in_range;
         rd_keep_d = !acc_we && acc_in_range;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         rd_keep_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         be_q      <= be_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         rd_keep_q <= rd_keep_d;
      end
   end

   for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      assign lane_we[gi] = commit && acc_we && acc_in_range && acc_be[gi];
   end
   assign mem_re = commit && !acc_we && acc_in_range;

   // Storage has no reset so it maps onto block RAM with a registered read port.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BE_W; b++) begin
         if (lane_we[b]) begin
            mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8] ^ acc_init[b*8 +: 8];
         end
      end
      if (mem_re) begin
         mem_rd_q  <= mem[acc_idx];
         rd_init_q <= acc_init;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = err_q;
   assign rsp_rdata = rd_keep_q ? (mem_rd_q ^ rd_init_q) : '0;

`ifdef DMEM_PERF_CNT_EN
   logic [31:0] rd_count_q, rd_count_d;
   logic [31:0] wr_count_q, wr_count_d;

   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (mem_re) rd_count_d = rd_count_q + 32'd1;
      if (commit && acc_we && acc_in_range) wr_count_d = wr_count_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: instance 0 has two wait states, instance 1 has none.
// Expected data comes from a word-array model updated with the byte-enable rules.
module tb_data_mem_ctrl;
   localparam int DW    = 32;
   localparam int AW    = 7;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic reset;
   logic          req_valid [2];
   logic          req_ready [2];
   logic          req_we    [2];
   logic [3:0]    req_be    [2];
   logic [AW-1:0] req_addr  [2];
   logic [DW-1:0] req_wdata [2];
   logic          rsp_valid [2];
   logic          rsp_ready [2];
   logic [DW-1:0] rsp_rdata [2];
   logic          rsp_err   [2];
`ifdef DMEM_PERF_CNT_EN
   logic [31:0]   rd_count  [2];
   logic [31:0]   wr_count  [2];
`endif

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] mdl [2][DEPTH];

   typedef struct {
      logic [DW-1:0] rd;
      logic          err;
      int            edges;
      bit            busy_ok;
      bit            timeout;
      logic          post_valid;
      logic [DW-1:0] post_rdata;
      logic          post_ready;
   } obs_t;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(2)) u_dut_lat2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0])
`ifdef DMEM_PERF_CNT_EN
      , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
   );

   data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(0)) u_dut_lat0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1])
`ifdef DMEM_PERF_CNT_EN
      , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
   );

   function automatic int lat_of(input int s);
      return (s == 0) ? 2 : 0;
   endfunction

   // Reference behaviour: out-of-range -> error, no storage change; write merges
   // enabled bytes and returns 0; read returns the whole word.
   task automatic model_txn(input int s, input logic we, input logic [3:0] be,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            output logic [DW-1:0] erd, output logic eerr);
      erd  = '0;
      eerr = (int'(addr) >= DEPTH);
      if (!eerr) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mdl[s][addr[5:0]][8*b +: 8] = wd[8*b +: 8];
            end
         end else begin
            erd = mdl[s][addr[5:0]];
         end
      end
   endtask

   // Drives one request with rsp_ready high and reports what the DUT did.
   task automatic run_txn(input int s, input logic we, input logic [3:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd, output obs_t o);
      o.rd = '0; o.err = 1'b0; o.edges = 0; o.busy_ok = 1'b1; o.timeout = 1'b0;
      o.post_valid = 1'b0; o.post_rdata = '0; o.post_ready = 1'b0;
      @(negedge clk);
      req_valid[s] = 1'b1; req_we[s] = we; req_be[s] = be;
      req_addr[s] = addr; req_wdata[s] = wd; rsp_ready[s] = 1'b1;
      @(posedge clk);
      #1 req_valid[s] = 1'b0;
      @(negedge clk);
      while (rsp_valid[s] !== 1'b1) begin
         if (req_ready[s] !== 1'b0) o.busy_ok = 1'b0;
         if (o.edges >= 40) begin
            o.timeout = 1'b1;
            break;
         end
         @(negedge clk);
         o.edges++;
      end
      if (!o.timeout) begin
         if (req_ready[s] !== 1'b0) o.busy_ok = 1'b0;
         o.rd  = rsp_rdata[s];
         o.err = rsp_err[s];
         @(negedge clk);
         o.post_valid = rsp_valid[s];
         o.post_rdata = rsp_rdata[s];
         o.post_ready = req_ready[s];
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         total++; if (rsp_valid[s] !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid dut%0d got=%b want=0", s, rsp_valid[s]); end
         total++; if (rsp_rdata[s] !== '0) begin bad++; $display("FAIL reset_rsp_rdata dut%0d got=%h want=0", s, rsp_rdata[s]); end
         total++; if (rsp_err[s] !== 1'b0) begin bad++; $display("FAIL reset_rsp_err dut%0d got=%b want=0", s, rsp_err[s]); end
         total++; if (req_ready[s] !== 1'b1) begin bad++; $display("FAIL reset_req_ready dut%0d got=%b want=1", s, req_ready[s]); end
      end
   endtask

   task automatic test_read_basic();
      obs_t o; logic [DW-1:0] erd; logic eerr;
      model_txn(0, 1'b0, 4'h0, 7'd1, '0, erd, eerr);
      run_txn(0, 1'b0, 4'h0, 7'd1, '0, o);
      $display("txn read_basic: addr=1 rd=%h err=%b edges=%0d", o.rd, o.err, o.edges);
      total++; if (o.timeout) begin bad++; $display("FAIL rd1_timeout got=1 want=0"); end
      total++; if (o.edges != lat_of(0)) begin bad++; $display("FAIL rd1_latency got=%0d want=%0d", o.edges, lat_of(0)); end
      total++; if (o.rd !== 32'd9 || o.rd !== erd) begin bad++; $display("FAIL rd1_data got=%h want=%h", o.rd, erd); end
      total++; if (o.err !== 1'b0) begin bad++; $display("FAIL rd1_err got=%b want=0", o.err); end
      total++; if (!o.busy_ok) begin bad++; $display("FAIL rd1_ready_low got=high want=low"); end
      total++; if (o.post_valid !== 1'b0 || o.post_rdata !== '0 || o.post_ready !== 1'b1) begin
         bad++; $display("FAIL rd1_release got=v%b d%h r%b want=v0 d0 r1", o.post_valid, o.post_rdata, o.post_ready);
      end
   endtask

   task automatic test_byte_enable();
      obs_t o; logic [DW-1:0] erd; logic eerr;
      model_txn(0, 1'b1, 4'b0101, 7'd5, 32'hAABBCCDD, erd, eerr);
      run_txn(0, 1'b1, 4'b0101, 7'd5, 32'hAABBCCDD, o);
      $display("txn be_write: addr=5 be=0101 rd=%h err=%b", o.rd, o.err);
      total++; if (o.rd !== '0 || o.err !== 1'b0) begin bad++; $display("FAIL be_write_rsp got=%h/%b want=0/0", o.rd, o.err); end
      model_txn(0, 1'b0, 4'h0, 7'd5, '0, erd, eerr);
      run_txn(0, 1'b0, 4'h0, 7'd5, '0, o);
      $display("txn be_read: addr=5 rd=%h err=%b", o.rd, o.err);
      total++; if (o.rd !== 32'h00BB00DD || o.rd !== erd) begin bad++; $display("FAIL be_read got=%h want=%h", o.rd, erd); end
      // Zero byte enables: normal response, storage untouched.
      model_txn(0, 1'b1, 4'b0000, 7'd5, 32'h11111111, erd, eerr);
      run_txn(0, 1'b1, 4'b0000, 7'd5, 32'h11111111, o);
      total++; if (o.err !== 1'b0 || o.edges != lat_of(0)) begin bad++; $display("FAIL be0_write got=err%b lat%0d want=err0 lat%0d", o.err, o.edges, lat_of(0)); end
      model_txn(0, 1'b0, 4'hF, 7'd5, '0, erd, eerr);
      run_txn(0, 1'b0, 4'hF, 7'd5, '0, o);
      total++; if (o.rd !== erd) begin bad++; $display("FAIL be0_read got=%h want=%h", o.rd, erd); end
   endtask

   task automatic test_out_of_range();
      obs_t o; logic [DW-1:0] erd; logic eerr;
      model_txn(0, 1'b0, 4'hF, 7'd70, '0, erd, eerr);
      run_txn(0, 1'b0, 4'hF, 7'd70, '0, o);
      $display("txn oor_read: addr=70 rd=%h err=%b edges=%0d", o.rd, o.err, o.edges);
      total++; if (o.err !== 1'b1 || o.rd !== '0) begin bad++; $display("FAIL oor_read got=%h/%b want=0/1", o.rd, o.err); end
      total++; if (o.edges != lat_of(0)) begin bad++; $display("FAIL oor_latency got=%0d want=%0d", o.edges, lat_of(0)); end
      model_txn(0, 1'b1, 4'hF, 7'd70, 32'h5A5A5A5A, erd, eerr);
      run_txn(0, 1'b1, 4'hF, 7'd70, 32'h5A5A5A5A, o);
      total++; if (o.err !== 1'b1) begin bad++; $display("FAIL oor_write_err got=%b want=1", o.err); end
      // Address 70 aliases word 6 in the low bits; that word must be untouched.
      model_txn(0, 1'b0, 4'hF, 7'd6, '0, erd, eerr);
      run_txn(0, 1'b0, 4'hF, 7'd6, '0, o);
      total++; if (o.rd !== erd || o.err !== 1'b0) begin bad++; $display("FAIL oor_alias got=%h/%b want=%h/0", o.rd, o.err, erd); end
   endtask

   task automatic test_backpressure();
      obs_t o; logic [DW-1:0] erd; logic eerr; int n;
      model_txn(0, 1'b0, 4'hF, 7'd2, '0, erd, eerr);
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 7'd2; req_be[0] = 4'h0; rsp_ready[0] = 1'b0;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (rsp_valid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      total++; if (rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b want=1", rsp_valid[0]); end
      for (int i = 0; i < 4; i++) begin
         total++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'd25 || rsp_rdata[0] !== erd) begin
            bad++; $display("FAIL bp_hold%0d got=v%b d%h want=v1 d%h", i, rsp_valid[0], rsp_rdata[0], erd);
         end
         total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b want=0", i, req_ready[0]); end
         if (i == 1) begin
            req_valid[0] = 1'b1; req_we[0] = 1'b1; req_be[0] = 4'hF; req_addr[0] = 7'd2; req_wdata[0] = 32'hDEADBEEF;
         end
         if (i == 3) req_valid[0] = 1'b0;
         @(negedge clk);
      end
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      total++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== '0) begin
         bad++; $display("FAIL bp_release got=r%b v%b d%h want=r1 v0 d0", req_ready[0], rsp_valid[0], rsp_rdata[0]);
      end
      run_txn(0, 1'b0, 4'hF, 7'd2, '0, o);
      total++; if (o.rd !== erd) begin bad++; $display("FAIL bp_ignored_write got=%h want=%h", o.rd, erd); end
   endtask

   task automatic test_back_to_back();
      int acc[$]; int resp_n; int n_bad_data;
      resp_n = 0; n_bad_data = 0;
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 7'd0; req_be[0] = 4'hF; rsp_ready[0] = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (req_ready[0] === 1'b1) acc.push_back(cyc);
         if (rsp_valid[0] === 1'b1) begin
            resp_n++;
            if (rsp_rdata[0] !== mdl[0][0]) n_bad_data++;
         end
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      $display("txn back_to_back: accepts=%0d responses=%0d", acc.size(), resp_n);
      total++; if (acc.size() != 3) begin bad++; $display("FAIL b2b_accepts got=%0d want=3", acc.size()); end
      for (int i = 1; i < acc.size(); i++) begin
         total++; if (acc[i] - acc[i-1] != lat_of(0) + 2) begin
            bad++; $display("FAIL b2b_period got=%0d want=%0d", acc[i] - acc[i-1], lat_of(0) + 2);
         end
      end
      total++; if (resp_n != 3 || n_bad_data != 0) begin bad++; $display("FAIL b2b_data got=%0d resp %0d bad want=3 resp 0 bad", resp_n, n_bad_data); end
   endtask

   task automatic test_reset_mid();
      obs_t o; logic [DW-1:0] erd; logic eerr; int n;
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 7'd1; rsp_ready[0] = 1'b0;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (rsp_valid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      total++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== mdl[0][1]) begin bad++; $display("FAIL rst_pre got=v%b d%h want=v1 d%h", rsp_valid[0], rsp_rdata[0], mdl[0][1]); end
      #2 reset = 1'b1;
      #1;
      total++; if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== '0 || rsp_err[0] !== 1'b0) begin
         bad++; $display("FAIL rst_async got=v%b d%h e%b want=v0 d0 e0", rsp_valid[0], rsp_rdata[0], rsp_err[0]);
      end
      @(negedge clk);
      reset = 1'b0; rsp_ready[0] = 1'b1;
      // Write to word 3 killed by reset while still counting wait states.
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_be[0] = 4'hF; req_addr[0] = 7'd3; req_wdata[0] = 32'h1234;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_txn(0, 1'b0, 4'hF, 7'd3, '0, erd, eerr);
      run_txn(0, 1'b0, 4'hF, 7'd3, '0, o);
      $display("txn reset_mid: addr=3 rd=%h", o.rd);
      total++; if (o.rd !== '0 || o.rd !== erd) begin bad++; $display("FAIL rst_dropped_write got=%h want=%h", o.rd, erd); end
   endtask

   task automatic test_perf_lat0();
      obs_t o; logic [DW-1:0] erd; logic eerr;
      int rd_exp; int wr_exp;
      logic          t_we   [7];
      logic [AW-1:0] t_addr [7];
      logic [DW-1:0] t_wd   [7];
      t_we   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      t_addr = '{7'd0, 7'd10, 7'd10, 7'd11, 7'd1, 7'd2, 7'd100};
      t_wd   = '{32'h0, 32'hCAFEBABE, 32'h0, 32'h0BADF00D, 32'h0, 32'h0, 32'h77777777};
      rd_exp = 0; wr_exp = 0;
      for (int i = 0; i < 7; i++) begin
         model_txn(1, t_we[i], 4'hF, t_addr[i], t_wd[i], erd, eerr);
         if (!eerr && t_we[i]) wr_exp++;
         if (!eerr && !t_we[i]) rd_exp++;
         run_txn(1, t_we[i], 4'hF, t_addr[i], t_wd[i], o);
         $display("txn lat0 %0d: we=%b addr=%0d rd=%h err=%b edges=%0d", i, t_we[i], t_addr[i], o.rd, o.err, o.edges);
         total++; if (o.timeout || o.edges != 0) begin bad++; $display("FAIL lat0_latency%0d got=%0d want=0", i, o.edges); end
         total++; if (o.rd !== erd || o.err !== eerr) begin bad++; $display("FAIL lat0_rsp%0d got=%h/%b want=%h/%b", i, o.rd, o.err, erd, eerr); end
      end
`ifdef DMEM_PERF_CNT_EN
      total++; if (rd_count[1] !== 32'(rd_exp)) begin bad++; $display("FAIL perf_rd got=%0d want=%0d", rd_count[1], rd_exp); end
      total++; if (wr_count[1] !== 32'(wr_exp)) begin bad++; $display("FAIL perf_wr got=%0d want=%0d", wr_count[1], wr_exp); end
`endif
   endtask

   task automatic test_random();
      obs_t o; logic [DW-1:0] erd; logic eerr;
      logic we; logic [3:0] be; logic [AW-1:0] addr; logic [DW-1:0] wd;
      for (int i = 0; i < 40; i++) begin
         we   = 1'($urandom_range(0, 1));
         be   = 4'($urandom_range(0, 15));
         addr = 7'($urandom_range(0, 79));
         wd   = $urandom;
         model_txn(0, we, be, addr, wd, erd, eerr);
         run_txn(0, we, be, addr, wd, o);
         $display("txn rand %0d: we=%b be=%h addr=%0d wd=%h -> rd=%h err=%b", i, we, be, addr, wd, o.rd, o.err);
         total++; if (o.timeout || o.edges != lat_of(0)) begin bad++; $display("FAIL rand_latency%0d got=%0d want=%0d", i, o.edges, lat_of(0)); end
         total++; if (o.rd !== erd) begin bad++; $display("FAIL rand_rdata%0d got=%h want=%h", i, o.rd, erd); end
         total++; if (o.err !== eerr) begin bad++; $display("FAIL rand_err%0d got=%b want=%b", i, o.err, eerr); end
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         req_valid[s] = 1'b0; req_we[s] = 1'b0; req_be[s] = '0;
         req_addr[s] = '0; req_wdata[s] = '0; rsp_ready[s] = 1'b1;
         for (int a = 0; a < DEPTH; a++) mdl[s][a] = '0;
         mdl[s][0] = 32'd17; mdl[s][1] = 32'd9; mdl[s][2] = 32'd25;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      test_reset();
      test_read_basic();
      test_byte_enable();
      test_out_of_range();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_perf_lat0();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
